// File: rtl/phyccgen_pkg.sv
// Shared constants for the auxiliary CC signal generator: state codes,
// ack codes and default cycle counts for a 12MHz clk.
package phyccgen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_FRS   = 3'd2;
  localparam state_t ST_GUARD = 3'd3;
  localparam state_t ST_BIST  = 3'd4;

  localparam logic [1:0] ACK_NONE = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] NAK      = 2'd2;

  localparam int DEF_FRS_CYC   = 1080;
  localparam int DEF_GUARD_CYC = 24;
  localparam int DEF_UI_CYC    = 40;
  localparam int DEF_BIST_CYC  = 540000;
  localparam int DEF_BIST_NBT  = 20;

endpackage

// File: rtl/phycg_tmr.sv
// Loadable down-counter that parks at zero; zero flags the end of a period.
module phycg_tmr #(
  parameter int NBT = 20
) (
  input  logic           clk,
  input  logic           srstz,
  input  logic           load,
  input  logic [NBT-1:0] load_val,
  output logic           zero
);

  logic [NBT-1:0] cnt;

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/phyccgen.sv
// CC line signal generator for FR_Swap requests and BIST carrier mode,
// arbitrating against the BMC transmitter and reporting ACK/NAK pulses.
module phyccgen
  import phyccgen_pkg::*;
#(
  parameter int FRS_CYC   = DEF_FRS_CYC,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int UI_CYC    = DEF_UI_CYC,
  parameter int BIST_CYC  = DEF_BIST_CYC,
  parameter int BIST_NBT  = DEF_BIST_NBT
) (
  input  logic       clk,
  input  logic       srstz,
  input  logic       r_frs_req,
  input  logic       r_bist_req,
  input  logic       r_abort,
  input  logic       ptx_txact,
  input  logic       pid_ccidle,
  output logic       pcg_cc,
  output logic       pcg_oe,
  output logic       pcg_busy,
  output logic [1:0] pcg_ack,
  output logic [2:0] pcg_fsm
);

  localparam logic [BIST_NBT-1:0] FRS_LD   = BIST_NBT'(FRS_CYC - 1);
  localparam logic [BIST_NBT-1:0] GUARD_LD = BIST_NBT'(GUARD_CYC - 1);
  localparam logic [BIST_NBT-1:0] UI_LD    = BIST_NBT'(UI_CYC - 1);
  localparam logic [BIST_NBT-1:0] BIST_LD  = BIST_NBT'(BIST_CYC - 1);

  state_t               state, nxt_state;
  logic                 pend_frs, nxt_pend, pend_now;
  logic [1:0]           exit_code, nxt_code, nxt_ack;
  logic                 nxt_cc, nxt_oe;
  logic                 go_frs, go_bist, go_guard;
  logic                 tmr_load, ui_load, tmr_zero, ui_zero;
  logic [BIST_NBT-1:0]  tmr_val;

  // Main timer covers FRS, GUARD and BIST total; the UI timer runs alongside BIST.
  phycg_tmr #(.NBT(BIST_NBT)) u_tmr (
    .clk      (clk),
    .srstz    (srstz),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  phycg_tmr #(.NBT(BIST_NBT)) u_ui (
    .clk      (clk),
    .srstz    (srstz),
    .load     (ui_load),
    .load_val (UI_LD),
    .zero     (ui_zero)
  );

  always_comb begin
    nxt_state = state;
    nxt_pend  = pend_frs;
    nxt_code  = exit_code;
    nxt_ack   = ACK_NONE;
    nxt_cc    = pcg_cc;
    nxt_oe    = pcg_oe;
    pend_now  = pend_frs;
    go_frs    = 1'b0;
    go_bist   = 1'b0;
    go_guard  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    ui_load   = 1'b0;

    case (state)
      ST_IDLE: begin
        nxt_cc = 1'b0;
        nxt_oe = 1'b0;
        if (r_frs_req) begin
          if (r_bist_req) nxt_ack = NAK;
          if (ptx_txact) begin
            nxt_state = ST_WAIT;
            nxt_pend  = 1'b1;
          end else begin
            go_frs = 1'b1;
          end
        end else if (r_bist_req) begin
          if (ptx_txact) begin
            nxt_state = ST_WAIT;
            nxt_pend  = 1'b0;
          end else if (pid_ccidle) begin
            go_bist = 1'b1;
          end else begin
            nxt_ack = NAK;
          end
        end
      end

      ST_WAIT: begin
        nxt_cc = 1'b0;
        nxt_oe = 1'b0;
        if (r_abort) begin
          nxt_state = ST_IDLE;
          nxt_ack   = NAK;
        end else begin
          // An FRS request while BIST is pending silently upgrades the pending type.
          pend_now = pend_frs | r_frs_req;
          nxt_pend = pend_now;
          if ((r_frs_req && pend_frs) || r_bist_req) nxt_ack = NAK;
          if (!ptx_txact) begin
            if (pend_now) begin
              go_frs = 1'b1;
            end else if (pid_ccidle) begin
              go_bist = 1'b1;
            end else begin
              nxt_state = ST_IDLE;
              nxt_ack   = NAK;
            end
          end
        end
      end

      ST_FRS: begin
        if (r_frs_req || r_bist_req) nxt_ack = NAK;
        if (tmr_zero) go_guard = 1'b1;
      end

      ST_BIST: begin
        if (r_frs_req) begin
          go_frs = 1'b1;
        end else begin
          if (r_bist_req) nxt_ack = NAK;
          if (r_abort) begin
            go_guard = 1'b1;
            nxt_code = NAK;
          end else if (tmr_zero) begin
            go_guard = 1'b1;
          end else if (ui_zero) begin
            nxt_cc  = ~pcg_cc;
            ui_load = 1'b1;
          end
        end
      end

      ST_GUARD: begin
        if (r_frs_req || r_bist_req || r_abort) nxt_ack = NAK;
        if (tmr_zero) begin
          nxt_state = ST_IDLE;
          nxt_ack   = exit_code;
        end
      end

      default: begin
        nxt_state = ST_IDLE;
        nxt_cc    = 1'b0;
        nxt_oe    = 1'b0;
      end
    endcase

    if (go_frs) begin
      nxt_state = ST_FRS;
      nxt_oe    = 1'b1;
      nxt_cc    = 1'b0;
      nxt_code  = ACK;
      tmr_load  = 1'b1;
      tmr_val   = FRS_LD;
    end
    if (go_bist) begin
      nxt_state = ST_BIST;
      nxt_oe    = 1'b1;
      nxt_cc    = 1'b1;
      nxt_code  = ACK;
      tmr_load  = 1'b1;
      tmr_val   = BIST_LD;
      ui_load   = 1'b1;
    end
    if (go_guard) begin
      nxt_state = ST_GUARD;
      nxt_oe    = 1'b0;
      nxt_cc    = 1'b0;
      tmr_load  = 1'b1;
      tmr_val   = GUARD_LD;
    end
  end

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      state     <= ST_IDLE;
      pend_frs  <= 1'b0;
      exit_code <= ACK_NONE;
      pcg_cc    <= 1'b0;
      pcg_oe    <= 1'b0;
      pcg_busy  <= 1'b0;
      pcg_ack   <= ACK_NONE;
    end else begin
      state     <= nxt_state;
      pend_frs  <= nxt_pend;
      exit_code <= nxt_code;
      pcg_cc    <= nxt_cc;
      pcg_oe    <= nxt_oe;
      pcg_busy  <= (nxt_state != ST_IDLE);
      pcg_ack   <= nxt_ack;
    end
  end

  assign pcg_fsm = state;

endmodule

// File: tb/tb_phyccgen.sv
// Self-checking bench for phyccgen; expectations come from a phase model
// (active length, guard length, exit code) evaluated per observed cycle.
module tb_phyccgen;

  localparam int FRS   = 1080;
  localparam int GUARD = 24;
  localparam int UI    = 40;
  localparam int BCYC  = 3000;
  localparam logic [1:0] ACK = 2'd1;
  localparam logic [1:0] NAK = 2'd2;

  logic       clk;
  logic       srstz;
  logic       r_frs_req, r_bist_req, r_abort, ptx_txact, pid_ccidle;
  logic       pcg_cc, pcg_oe, pcg_busy;
  logic [1:0] pcg_ack;
  logic [2:0] pcg_fsm;

  int errors = 0;
  int checks = 0;

  // BIST total shortened so the auto-stop path fits in a short run.
  phyccgen #(.BIST_CYC(BCYC)) dut (
    .clk        (clk),
    .srstz      (srstz),
    .r_frs_req  (r_frs_req),
    .r_bist_req (r_bist_req),
    .r_abort    (r_abort),
    .ptx_txact  (ptx_txact),
    .pid_ccidle (pid_ccidle),
    .pcg_cc     (pcg_cc),
    .pcg_oe     (pcg_oe),
    .pcg_busy   (pcg_busy),
    .pcg_ack    (pcg_ack),
    .pcg_fsm    (pcg_fsm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] obs();
    return {pcg_fsm, pcg_oe, pcg_cc, pcg_busy, pcg_ack};
  endfunction

  // Expected {fsm, oe, cc, busy, ack} k cycles after an operation starts:
  // len active cycles, GUARD quiet cycles, then one idle cycle carrying code.
  function automatic logic [7:0] exp_run(int k, bit bist, int len, logic [1:0] code);
    logic [7:0] v;
    if (k < len)
      v = {(bist ? 3'd4 : 3'd2), 1'b1, 1'(bist && ((k / UI) % 2 == 0)), 1'b1, 2'd0};
    else if (k < len + GUARD)
      v = {3'd3, 1'b0, 1'b0, 1'b1, 2'd0};
    else if (k == len + GUARD)
      v = {3'd0, 1'b0, 1'b0, 1'b0, code};
    else
      v = 8'd0;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 4)) begin
      pid_ccidle = 1'($urandom_range(0, 1));
      cyc();
    end
    pid_ccidle = 1'b1;
  endtask

  task automatic test_reset();
    srstz = 1'b0;
    r_frs_req = 0; r_bist_req = 0; r_abort = 0; ptx_txact = 0; pid_ccidle = 1;
    repeat (3) cyc();
    checks++;
    if (obs() !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got=%b exp=%b", obs(), 8'd0);
    end
    #2 srstz = 1'b1;
    cyc();
    checks++;
    if (obs() !== 8'd0) begin
      errors++;
      $display("[TB] FAIL after_reset_idle got=%b exp=%b", obs(), 8'd0);
    end
  endtask

  task automatic test_frs_basic();
    for (int it = 0; it < 2; it++) begin
      int nak_k, ab_k, g_k;
      logic [7:0] e;
      idle_gap();
      nak_k = $urandom_range(10, FRS - 10);
      ab_k  = $urandom_range(10, FRS - 10);
      g_k   = FRS + $urandom_range(0, GUARD - 2);
      r_frs_req = 1; cyc(); r_frs_req = 0;
      for (int k = 0; k <= FRS + GUARD + 1; k++) begin
        e = exp_run(k, 0, FRS, ACK);
        if (k == nak_k + 1 || k == g_k + 1) e[1:0] = NAK;
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("[TB] FAIL frs_basic k=%0d got=%b exp=%b", k, obs(), e);
        end
        r_bist_req = (k == nak_k);
        r_abort    = (k == ab_k);
        r_frs_req  = (k == g_k);
        pid_ccidle = 1'($urandom_range(0, 1));
        cyc();
      end
      r_bist_req = 0; r_abort = 0; r_frs_req = 0; pid_ccidle = 1;
    end
  endtask

  task automatic test_frs_deferred();
    int w;
    logic [7:0] e;
    idle_gap();
    ptx_txact = 1;
    r_frs_req = 1; cyc(); r_frs_req = 0;
    w = $urandom_range(1, 20);
    for (int i = 0; i < w; i++) begin
      checks++;
      if (obs() !== {3'd1, 1'b0, 1'b0, 1'b1, 2'd0}) begin
        errors++;
        $display("[TB] FAIL frs_wait i=%0d got=%b exp=%b", i, obs(), {3'd1, 1'b0, 1'b0, 1'b1, 2'd0});
      end
      cyc();
    end
    ptx_txact = 0;
    cyc();
    for (int k = 0; k <= FRS + GUARD + 1; k++) begin
      e = exp_run(k, 0, FRS, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL frs_deferred k=%0d got=%b exp=%b", k, obs(), e);
      end
      cyc();
    end
  endtask

  task automatic test_bist_abort(input int a);
    int nak_k;
    logic [7:0] e;
    idle_gap();
    nak_k = $urandom_range(1, a - 2);
    r_bist_req = 1; cyc(); r_bist_req = 0;
    for (int k = 0; k <= a + GUARD + 2; k++) begin
      e = exp_run(k, 1, a + 1, NAK);
      if (k == nak_k + 1) e[1:0] = NAK;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL bist_abort a=%0d k=%0d got=%b exp=%b", a, k, obs(), e);
      end
      r_abort    = (k == a);
      r_bist_req = (k == nak_k);
      cyc();
    end
    r_abort = 0; r_bist_req = 0;
  endtask

  task automatic test_bist_timeout();
    logic [7:0] e;
    idle_gap();
    r_bist_req = 1; cyc(); r_bist_req = 0;
    for (int k = 0; k <= BCYC + GUARD + 1; k++) begin
      e = exp_run(k, 1, BCYC, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL bist_timeout k=%0d got=%b exp=%b", k, obs(), e);
      end
      pid_ccidle = 1'($urandom_range(0, 1));
      cyc();
    end
    pid_ccidle = 1;
  endtask

  task automatic test_bist_busy();
    pid_ccidle = 0; ptx_txact = 0;
    r_bist_req = 1; cyc(); r_bist_req = 0;
    checks++;
    if (obs() !== {3'd0, 1'b0, 1'b0, 1'b0, NAK}) begin
      errors++;
      $display("[TB] FAIL bist_busy_nak got=%b exp=%b", obs(), {3'd0, 1'b0, 1'b0, 1'b0, NAK});
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (obs() !== 8'd0) begin
        errors++;
        $display("[TB] FAIL bist_busy_idle i=%0d got=%b exp=%b", i, obs(), 8'd0);
      end
    end
    pid_ccidle = 1;
  endtask

  task automatic test_preempt();
    int p;
    logic [7:0] e;
    idle_gap();
    p = $urandom_range(50, 300);
    r_bist_req = 1; cyc(); r_bist_req = 0;
    for (int k = 0; k <= p + FRS + GUARD + 2; k++) begin
      if (k <= p) e = exp_run(k, 1, BCYC, ACK);
      else        e = exp_run(k - p - 1, 0, FRS, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL preempt p=%0d k=%0d got=%b exp=%b", p, k, obs(), e);
      end
      r_frs_req = (k == p);
      cyc();
    end
    r_frs_req = 0;
  endtask

  task automatic test_collision();
    logic [7:0] e;
    idle_gap();
    r_frs_req = 1; r_bist_req = 1; cyc(); r_frs_req = 0; r_bist_req = 0;
    for (int k = 0; k <= FRS + GUARD + 1; k++) begin
      e = exp_run(k, 0, FRS, ACK);
      if (k == 0) e[1:0] = NAK;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL collision k=%0d got=%b exp=%b", k, obs(), e);
      end
      cyc();
    end
  endtask

  task automatic test_wait();
    logic [7:0] e;
    // Pending BIST upgraded to FRS without a NAK.
    ptx_txact = 1;
    r_bist_req = 1; cyc(); r_bist_req = 0;
    r_frs_req = 1; cyc(); r_frs_req = 0;
    checks++;
    if (obs() !== {3'd1, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL wait_upgrade got=%b exp=%b", obs(), {3'd1, 1'b0, 1'b0, 1'b1, 2'd0});
    end
    ptx_txact = 0; cyc();
    for (int k = 0; k <= FRS + GUARD + 1; k++) begin
      e = exp_run(k, 0, FRS, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL wait_upgrade_frs k=%0d got=%b exp=%b", k, obs(), e);
      end
      cyc();
    end
    // Abort while waiting.
    ptx_txact = 1;
    r_bist_req = 1; cyc(); r_bist_req = 0;
    r_abort = 1; cyc(); r_abort = 0;
    checks++;
    if (obs() !== {3'd0, 1'b0, 1'b0, 1'b0, NAK}) begin
      errors++;
      $display("[TB] FAIL wait_abort got=%b exp=%b", obs(), {3'd0, 1'b0, 1'b0, 1'b0, NAK});
    end
    // Pending BIST finds the line busy when the transmitter finishes.
    r_bist_req = 1; cyc(); r_bist_req = 0;
    pid_ccidle = 0; ptx_txact = 0; cyc();
    checks++;
    if (obs() !== {3'd0, 1'b0, 1'b0, 1'b0, NAK}) begin
      errors++;
      $display("[TB] FAIL wait_bist_busy got=%b exp=%b", obs(), {3'd0, 1'b0, 1'b0, 1'b0, NAK});
    end
    // Pending BIST starts on an idle line, then is aborted at once.
    pid_ccidle = 1; ptx_txact = 1; cyc();
    r_bist_req = 1; cyc(); r_bist_req = 0;
    ptx_txact = 0; cyc();
    for (int k = 0; k <= GUARD + 2; k++) begin
      e = exp_run(k, 1, 1, NAK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL wait_bist_start k=%0d got=%b exp=%b", k, obs(), e);
      end
      r_abort = (k == 0);
      cyc();
    end
    r_abort = 0;
  endtask

  task automatic test_reset_mid_frs();
    logic [7:0] e;
    idle_gap();
    r_frs_req = 1; cyc(); r_frs_req = 0;
    for (int k = 0; k < 500; k++) begin
      e = exp_run(k, 0, FRS, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_frs_pre k=%0d got=%b exp=%b", k, obs(), e);
      end
      cyc();
    end
    #2 srstz = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_async_drop got=%b exp=%b", obs(), 8'd0);
    end
    cyc();
    #2 srstz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs() !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_no_ack i=%0d got=%b exp=%b", i, obs(), 8'd0);
      end
    end
    r_frs_req = 1; cyc(); r_frs_req = 0;
    for (int k = 0; k <= FRS + GUARD + 1; k++) begin
      e = exp_run(k, 0, FRS, ACK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("[TB] FAIL reset_refrs k=%0d got=%b exp=%b", k, obs(), e);
      end
      cyc();
    end
  endtask

  initial begin
    $display("[TB] phyccgen bench start");
    test_reset();
    test_frs_basic();
    test_frs_deferred();
    test_bist_abort(400);
    test_bist_abort($urandom_range(100, 600));
    test_bist_busy();
    test_bist_timeout();
    test_preempt();
    test_collision();
    test_wait();
    test_reset_mid_frs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
